// File: rtl/line_reverser_pkg.sv
// line_reverser_pkg: shared state encoding, ASCII constants and case helper
package line_reverser_pkg;
  typedef enum logic [1:0] {FILL, DRAIN, TERM} state_e;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;
  function automatic logic [7:0] to_upper(logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? b - ASCII_CASE_DELTA : b;
  endfunction
endpackage

// File: rtl/line_reverser_if.sv
// line_reverser_if: byte stream valid/ready handshake
interface line_reverser_if;
  logic [7:0] data;
  logic valid;
  logic ready;
  modport master (output data, valid, input ready);
  modport slave (input data, valid, output ready);
endinterface

// File: rtl/line_reverser_buf.sv
// line_reverser_buf: DEPTH x 8 register store, one write port, registered write-first read port
module line_reverser_buf #(
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= (we_i && waddr_i == raddr_i) ? wdata_i : mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/line_reverser.sv
// line_reverser: buffers a line, emits it reversed then its terminator; LINE_REVERSER_UPCASE_EN upcases drained letters
module line_reverser
  import line_reverser_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0] term_q, term_d, rd_data, drain_byte;
  logic term_pending_q, term_pending_d, we, is_term;
  logic [AW-1:0] waddr, raddr;
  assign is_term = in_data == ASCII_CR || in_data == ASCII_LF;
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q <= FILL;
      count_q <= '0;
      term_q <= 8'h00;
      term_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q <= term_d;
      term_pending_q <= term_pending_d;
    end
  end
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d = term_q;
    term_pending_d = term_pending_q;
    we = 1'b0;
    unique case (state_q)
      FILL: if (in_valid) begin
        if (is_term) begin
          term_d = in_data;
          term_pending_d = 1'b1;
          state_d = (count_q != '0) ? DRAIN : TERM;
        end else begin
          we = 1'b1;
          count_d = count_q + CW'(1);
          if (count_q == CW'(DEPTH - 1)) begin
            state_d = DRAIN;
            term_pending_d = 1'b0;
          end
        end
      end
      DRAIN: if (out_ready) begin
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = term_pending_q ? TERM : FILL;
      end
      TERM: if (out_ready) begin
        state_d = FILL;
        term_pending_d = 1'b0;
      end
      default: state_d = FILL;
    endcase
  end
  // read address tracks next-state count so the registered read lands on buf[count-1]
  assign waddr = AW'(count_q);
  assign raddr = AW'(count_d - CW'(1));
  line_reverser_buf #(.DEPTH(DEPTH)) u_buf (
    .clk(clk_48mhz),
    .we_i(we),
    .waddr_i(waddr),
    .wdata_i(in_data),
    .raddr_i(raddr),
    .rdata_o(rd_data)
  );
`ifdef LINE_REVERSER_UPCASE_EN
  assign drain_byte = to_upper(rd_data);
`else
  assign drain_byte = rd_data;
`endif
  assign in_ready = state_q == FILL;
  assign out_valid = state_q != FILL;
  assign busy = state_q != FILL;
  assign out_data = state_q == DRAIN ? drain_byte : state_q == TERM ? term_q : 8'h00;
endmodule

// File: tb/tb_line_reverser.sv
// tb_line_reverser: directed and randomized checks of line_reverser against a line-level reference model
`timescale 1ns/1ps
module tb_line_reverser;
  typedef logic [7:0] u8;
  typedef u8 u8q[$];
  localparam u8 CR = 8'h0D;
  localparam u8 LF = 8'h0A;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  line_reverser_if a_in(), a_out(), b_in(), b_out();
  logic busy_a, busy_b;
  logic mode_a = 1'b0, mode_b = 1'b0, force_a = 1'b0, force_b = 1'b0, rnd_a = 1'b1, rnd_b = 1'b1;
  int errors = 0, checks = 0, viol_a = 0, viol_b = 0;
  u8 qa[$], qb[$];
  assign a_out.ready = mode_a ? force_a : rnd_a;
  assign b_out.ready = mode_b ? force_b : rnd_b;
  always @(negedge clk) begin
    rnd_a <= $urandom_range(0, 3) != 0;
    rnd_b <= $urandom_range(0, 3) != 0;
  end
  always @(posedge clk) begin
    if (a_out.valid && a_out.ready) qa.push_back(a_out.data);
    if (b_out.valid && b_out.ready) qb.push_back(b_out.data);
    if (a_out.valid && a_in.ready) viol_a <= viol_a + 1;
    if (b_out.valid && b_in.ready) viol_b <= viol_b + 1;
  end
  line_reverser dut_a (
    .clk_48mhz(clk), .reset(rst),
    .in_data(a_in.data), .in_valid(a_in.valid), .in_ready(a_in.ready),
    .out_data(a_out.data), .out_valid(a_out.valid), .out_ready(a_out.ready),
    .busy(busy_a)
  );
  line_reverser #(.DEPTH(4)) dut_b (
    .clk_48mhz(clk), .reset(rst),
    .in_data(b_in.data), .in_valid(b_in.valid), .in_ready(b_in.ready),
    .out_data(b_out.data), .out_valid(b_out.valid), .out_ready(b_out.ready),
    .busy(busy_b)
  );
  function automatic u8q line(string s, u8 t);
    u8q q;
    for (int i = 0; i < s.len(); i++) q.push_back(u8'(s[i]));
    q.push_back(t);
    return q;
  endfunction
  function automatic u8 up(u8 c);
`ifdef LINE_REVERSER_UPCASE_EN
    if (c >= "a" && c <= "z") return c - 8'd32;
`endif
    return c;
  endfunction
  // line-level reference: reverse each line on terminator or when it fills depth
  function automatic u8q model(u8q s, int depth);
    u8q e, ln;
    foreach (s[i]) begin
      if (s[i] == CR || s[i] == LF) begin
        for (int j = ln.size() - 1; j >= 0; j--) e.push_back(up(ln[j]));
        e.push_back(s[i]);
        ln = {};
      end else begin
        ln.push_back(s[i]);
        if (ln.size() == depth) begin
          for (int j = ln.size() - 1; j >= 0; j--) e.push_back(up(ln[j]));
          ln = {};
        end
      end
    end
    return e;
  endfunction
  function automatic bit same(u8q a, u8q b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction
  function automatic string hex(u8q q);
    string s = "";
    foreach (q[i]) if (i < 60) s = {s, $sformatf("%02h", q[i])};
    return s;
  endfunction
  function automatic logic rdy(int sel);
    return sel != 0 ? b_in.ready : a_in.ready;
  endfunction
  task automatic push(int sel, u8 b);
    int t = 0;
    @(negedge clk);
    if (sel != 0) begin b_in.data = b; b_in.valid = 1'b1; end
    else begin a_in.data = b; a_in.valid = 1'b1; end
    while (!rdy(sel) && t < 1000) begin @(negedge clk); t++; end
    checks++;
    if (t >= 1000) begin errors++; $display("FAIL push_timeout: in_ready got 0 for 1000 cycles, want 1"); end
    @(posedge clk); #1;
    a_in.valid = 1'b0;
    b_in.valid = 1'b0;
  endtask
  task automatic send(int sel, u8q s);
    foreach (s[i]) push(sel, s[i]);
  endtask
  task automatic drain(int sel, int n, output bit ok);
    int t = 0;
    while ((sel != 0 ? qb.size() : qa.size()) < n && t < 3000) begin @(negedge clk); t++; end
    repeat (8) @(negedge clk);
    ok = t < 3000;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    a_in.valid = 1'b0; a_in.data = 8'h00;
    b_in.valid = 1'b0; b_in.data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out.valid); end
    checks++; if (a_out.data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", a_out.data); end
    checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", a_in.ready); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (b_out.valid !== 1'b0 || b_out.data !== 8'h00) begin errors++; $display("FAIL reset_b_out: got %b/%h want 0/00", b_out.valid, b_out.data); end
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic test_basic;
    bit ok;
    u8q exp = line("cba", CR);
    qa = {};
    send(0, line("abc", CR));
    checks++; if (a_out.valid !== 1'b1 || a_out.data !== "c") begin errors++; $display("FAIL basic_latency: got %b/%h want 1/63", a_out.valid, a_out.data); end
    drain(0, exp.size(), ok);
    checks++; if (!ok || !same(qa, exp)) begin errors++; $display("FAIL basic_abc: got %s want %s", hex(qa), hex(exp)); end
  endtask
  task automatic test_lone_lf;
    bit ok;
    u8q exp = line("", LF);
    qa = {};
    push(0, LF);
    checks++; if (a_out.valid !== 1'b1 || a_out.data !== LF || busy_a !== 1'b1) begin errors++; $display("FAIL lone_lf_term: got %b/%h/%b want 1/0a/1", a_out.valid, a_out.data, busy_a); end
    drain(0, exp.size(), ok);
    checks++; if (!ok || !same(qa, exp)) begin errors++; $display("FAIL lone_lf: got %s want %s", hex(qa), hex(exp)); end
  endtask
  task automatic test_depth;
    bit ok;
    int v0 = viol_b;
    u8q exp = line("dcbafe", CR);
    qb = {};
    send(1, line("abc", "d"));
    checks++; if (b_out.valid !== 1'b1 || b_out.data !== "d") begin errors++; $display("FAIL depth_full_latency: got %b/%h want 1/64", b_out.valid, b_out.data); end
    send(1, line("ef", CR));
    drain(1, exp.size(), ok);
    checks++; if (!ok || !same(qb, exp)) begin errors++; $display("FAIL depth4_abcdef: got %s want %s", hex(qb), hex(exp)); end
    checks++; if (viol_b != v0) begin errors++; $display("FAIL depth_in_ready_in_drain: got %0d overlaps want 0", viol_b - v0); end
  endtask
  task automatic test_stall;
    bit ok;
    u8q exp = line("olleh", CR);
    qa = {};
    mode_a = 1'b1; force_a = 1'b0;
    send(0, line("hello", CR));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (a_out.valid !== 1'b1 || a_out.data !== 8'h6F) begin errors++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/6f", i, a_out.valid, a_out.data); end
    end
    force_a = 1'b1;
    drain(0, exp.size(), ok);
    checks++; if (!ok || !same(qa, exp)) begin errors++; $display("FAIL stall_hello: got %s want %s", hex(qa), hex(exp)); end
    mode_a = 1'b0;
  endtask
  task automatic test_reset_mid;
    bit ok;
    u8q part, exp;
    part.push_back("z"); part.push_back("y");
    exp = line("yx", LF);
    qa = {};
    mode_a = 1'b1; force_a = 1'b0;
    send(0, line("wxyz", LF));
    @(negedge clk) force_a = 1'b1;
    @(negedge clk);
    @(negedge clk) begin force_a = 1'b0; rst = 1'b1; end
    @(posedge clk); #1;
    checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid: got %b want 0", a_out.valid); end
    @(negedge clk) begin rst = 1'b0; mode_a = 1'b0; end
    repeat (12) @(negedge clk);
    checks++; if (!same(qa, part) || a_out.valid !== 1'b0) begin errors++; $display("FAIL reset_mid_discard: got %s valid=%b want %s valid=0", hex(qa), a_out.valid, hex(part)); end
    qa = {};
    send(0, line("xy", LF));
    drain(0, exp.size(), ok);
    checks++; if (!ok || !same(qa, exp)) begin errors++; $display("FAIL reset_mid_xy: got %s want %s", hex(qa), hex(exp)); end
  endtask
  task automatic test_case;
    bit ok;
`ifdef LINE_REVERSER_UPCASE_EN
    u8q exp = line("1ZA", CR);
`else
    u8q exp = line("1Za", CR);
`endif
    qa = {};
    send(0, line("aZ1", CR));
    drain(0, exp.size(), ok);
    checks++; if (!ok || !same(qa, exp)) begin errors++; $display("FAIL case_aZ1: got %s want %s", hex(qa), hex(exp)); end
  endtask
  task automatic test_random(int sel, int lines, int maxlen, int depth);
    bit ok;
    int va = viol_a, vb = viol_b;
    for (int n = 0; n < lines; n++) begin
      u8q s, exp;
      int len = $urandom_range(0, maxlen);
      for (int i = 0; i < len; i++) s.push_back(u8'($urandom_range(0, 255)));
      s.push_back($urandom_range(0, 1) != 0 ? CR : LF);
      exp = model(s, depth);
      qa = {}; qb = {};
      send(sel, s);
      drain(sel, exp.size(), ok);
      checks++;
      if (!ok || !same(sel != 0 ? qb : qa, exp)) begin
        errors++;
        $display("FAIL random_d%0d_line%0d: got %s want %s", depth, n, hex(sel != 0 ? qb : qa), hex(exp));
      end
    end
    checks++; if (viol_a != va || viol_b != vb) begin errors++; $display("FAIL random_in_ready_overlap: got %0d want 0", (viol_a - va) + (viol_b - vb)); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_lone_lf();
    test_depth();
    test_stall();
    test_reset_mid();
    test_case();
    test_random(0, 20, 90, 64);
    test_random(1, 15, 12, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/line_reverser.md
LINE_REVERSER -- requirements
Module: line_reverser

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the maximum number of buffered line bytes (power of two, 4..256).
REQ-002 SHALL have port clk_48mhz, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_data, input, 8 bits: upstream byte, popped from the receive FIFO.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is available.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 SHALL have port out_data, output, 8 bits: byte sent to the USB UART transmit path.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-010 SHALL have port busy, output, 1 bit: the block is not in FILL.

Function
REQ-011 SHALL transfer a byte on either port only in a cycle where valid and ready are both high.
REQ-012 SHALL implement states FILL, DRAIN and TERM.
REQ-013 In FILL: in_ready=1, out_valid=0.
REQ-014 In FILL, an accepted byte other than 0x0D or 0x0A SHALL be written to buf[count] and count SHALL increment.
REQ-015 In FILL, an accepted 0x0D or 0x0A SHALL be latched as term and term_pending set to 1; the next state is DRAIN if count>0, otherwise TERM.
REQ-016 In FILL, when a non-terminator byte brings count to DEPTH, the next state SHALL be DRAIN with term_pending=0.
REQ-017 In DRAIN: in_ready=0, out_valid=1, out_data=buf[count-1].
REQ-018 In DRAIN, each output handshake SHALL decrement count; when count reaches 0 the next state is TERM if term_pending, else FILL.
REQ-019 In TERM: in_ready=0, out_valid=1, out_data=term; on handshake the next state is FILL and term_pending is cleared.
REQ-020 out_valid and out_data SHALL be registered and SHALL have no combinational dependence on out_ready.
REQ-021 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Latency: the first output byte SHALL be valid in the cycle after the terminator or DEPTH-th byte is accepted.
REQ-023 in_ready SHALL have no combinational dependence on in_valid.
REQ-024 Each terminator SHALL be handled separately: CR LF produces the reversed line plus CR, then a lone LF.
REQ-025 count SHALL be $clog2(DEPTH)+1 bits wide and never wrap.
REQ-026 busy SHALL be 1 in DRAIN and TERM.

Reset
REQ-027 On reset: state=FILL, count=0, term_pending=0, term=0x00, out_valid=0, out_data=0x00.
REQ-028 Buffer contents SHALL NOT be cleared by reset.
REQ-029 Reset asserted mid-DRAIN or mid-TERM SHALL discard the pending line, and no further bytes of it SHALL be emitted.

Configuration
REQ-030 With LINE_REVERSER_UPCASE_EN defined, bytes 0x61..0x7A SHALL be emitted minus 0x20 in DRAIN; terminators and all other bytes are unchanged.
REQ-031 Without LINE_REVERSER_UPCASE_EN, bytes SHALL be emitted unmodified.

Structure
REQ-032 Package line_reverser_pkg SHALL hold the state enum (FILL, DRAIN, TERM) and constants ASCII_CR=0x0D, ASCII_LF=0x0A, ASCII_CASE_DELTA=0x20.
REQ-033 The byte store SHALL be the sub-module line_reverser_buf: DEPTH x 8 registers, one write port, one read port with registered output.

Verification
REQ-034 Input "abc\r" SHALL produce "cba\r", with out_valid high in the cycle after '\r' is accepted.
REQ-035 Input "\n" in FILL with count=0 SHALL produce a single "\n" directly from TERM.
REQ-036 With DEPTH=4, input "abcdef\r" SHALL produce "dcba", then "fe\r"; in_ready SHALL be 0 throughout each drain.
REQ-037 Input "hello\r" with out_ready held at 0 for 10 cycles after the first output SHALL hold out_data=0x6F stable, and the output SHALL still be "olleh\r".
REQ-038 Reset after 2 bytes of "wxyz\n" are drained SHALL give out_valid=0 the next cycle; a following input "xy\n" SHALL produce "yx\n".
REQ-039 Input "aZ1\r" SHALL produce "1ZA\r" with LINE_REVERSER_UPCASE_EN defined and "1Za\r" without it.
